// File: rtl/csr_intr_unit.sv
// Machine-mode CSR file and external interrupt front end: synchronizes intr, latches edges
// as pending, and holds mstatus/mtvec/mepc. Optional mcause register under `ifdef CSR_MCAUSE_EN.
module csr_intr_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        intr,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wd,
  input  logic [31:0] pc,
  input  logic        int_taken,
  input  logic        mret_exec,
  output logic        intr_req,
  output logic [31:0] csr_rd,
  output logic [31:0] mtvec,
  output logic [31:0] mepc,
  output logic        mie
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [31:0] ALIGN_MASK   = 32'hFFFF_FFFC;

  logic        sync_q1, sync_q2, sync_q3;
  logic [1:0]  warm;
  logic        armed;
  logic        intr_edge;
  logic        pending;
  logic        mie_q, mpie_q;
  logic [31:0] mtvec_q, mepc_q;

  logic we_mstatus, we_mtvec, we_mepc;
  assign we_mstatus = csr_we && (csr_addr == ADDR_MSTATUS);
  assign we_mtvec   = csr_we && (csr_addr == ADDR_MTVEC);
  assign we_mepc    = csr_we && (csr_addr == ADDR_MEPC);

  // Edges are only trusted once sync_q2 carries a real sample of intr and has been seen
  // low; otherwise a line already high at reset release would look like a fresh edge.
  assign intr_edge = armed & sync_q2 & ~sync_q3;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1  <= 1'b0;
      sync_q2  <= 1'b0;
      sync_q3  <= 1'b0;
      warm     <= 2'b00;
      armed    <= 1'b0;
      pending  <= 1'b0;
      intr_req <= 1'b0;
    end else begin
      sync_q1  <= intr;
      sync_q2  <= sync_q1;
      sync_q3  <= sync_q2;
      warm     <= {warm[0], 1'b1};
      armed    <= armed | (warm[1] & ~sync_q2);
      pending  <= intr_edge | (pending & ~int_taken);
      intr_req <= pending & mie_q;
    end
  end

  // Trap entry outranks mret, which outranks a CSR write, per register touched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_q   <= 1'b0;
      mpie_q  <= 1'b0;
      mtvec_q <= '0;
      mepc_q  <= '0;
    end else begin
      if (int_taken) begin
        mpie_q <= mie_q;
        mie_q  <= 1'b0;
      end else if (mret_exec) begin
        mie_q  <= mpie_q;
        mpie_q <= 1'b1;
      end else if (we_mstatus) begin
        mie_q  <= csr_wd[3];
        mpie_q <= csr_wd[7];
      end

      if (int_taken)
        mepc_q <= pc & ALIGN_MASK;
      else if (we_mepc)
        mepc_q <= csr_wd & ALIGN_MASK;

      if (we_mtvec)
        mtvec_q <= csr_wd & ALIGN_MASK;
    end
  end

`ifdef CSR_MCAUSE_EN
  logic [31:0] mcause_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      mcause_q <= '0;
    else if (int_taken)
      mcause_q <= 32'h8000_000B;
    else if (csr_we && (csr_addr == ADDR_MCAUSE))
      mcause_q <= csr_wd;
  end
`endif

  // NOTE: default assigned first so the read mux can never infer a latch.
  always_comb begin
    csr_rd = '0;
    case (csr_addr)
      ADDR_MSTATUS: csr_rd = {24'b0, mpie_q, 3'b000, mie_q, 3'b000};
      ADDR_MTVEC:   csr_rd = mtvec_q;
      ADDR_MEPC:    csr_rd = mepc_q;
`ifdef CSR_MCAUSE_EN
      ADDR_MCAUSE:  csr_rd = mcause_q;
`endif
      default:      csr_rd = '0;
    endcase
  end

  assign mtvec = mtvec_q;
  assign mepc  = mepc_q;
  assign mie   = mie_q;

endmodule

// File: tb/tb_csr_intr_unit.sv
// Directed bench for csr_intr_unit: expected values queued at stimulus time, popped at
// each observation point. Honours CSR_MCAUSE_EN for the mcause expectation.
module tb_csr_intr_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        intr;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wd;
  logic [31:0] pc;
  logic        int_taken;
  logic        mret_exec;
  logic        intr_req;
  logic [31:0] csr_rd;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        mie;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

`ifdef CSR_MCAUSE_EN
  localparam logic [31:0] MCAUSE_EXP = 32'h8000_000B;
`else
  localparam logic [31:0] MCAUSE_EXP = 32'h0;
`endif

  csr_intr_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .intr     (intr),
    .csr_we   (csr_we),
    .csr_addr (csr_addr),
    .csr_wd   (csr_wd),
    .pc       (pc),
    .int_taken(int_taken),
    .mret_exec(mret_exec),
    .intr_req (intr_req),
    .csr_rd   (csr_rd),
    .mtvec    (mtvec),
    .mepc     (mepc),
    .mie      (mie)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic push_exp(input string tag, input logic [31:0] value);
    exp_t e;
    e.tag   = tag;
    e.value = value;
    exp_q.push_back(e);
  endtask

  task automatic check(input logic [31:0] observed);
    exp_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%h expected=none", observed);
    end else begin
      e = exp_q.pop_front();
      assert (observed === e.value) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, observed, e.value);
      end
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_csr(input logic [11:0] addr, output logic [31:0] data);
    csr_addr = addr;
    #1;
    data = csr_rd;
  endtask

  task automatic write_csr(input logic [11:0] addr, input logic [31:0] data);
    csr_we   = 1'b1;
    csr_addr = addr;
    csr_wd   = data;
    step();
    csr_we   = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;

    rst_n = 1'b0; intr = 1'b0; csr_we = 1'b0; csr_addr = '0; csr_wd = '0;
    pc = '0; int_taken = 1'b0; mret_exec = 1'b0;
    #12;
    push_exp("reset_intr_req", 32'h0); check({31'b0, intr_req});
    push_exp("reset_mtvec", 32'h0);    check(mtvec);
    push_exp("reset_mepc", 32'h0);     check(mepc);
    push_exp("reset_mie", 32'h0);      check({31'b0, mie});
    @(negedge clk); rst_n = 1'b1;
    repeat (4) step();

    // mtvec / mepc low bits forced to zero; unmapped address ignored.
    write_csr(12'h305, 32'h0000_0103);
    push_exp("mtvec_out", 32'h0000_0100); check(mtvec);
    push_exp("mtvec_rd", 32'h0000_0100);  read_csr(12'h305, rd); check(rd);
    write_csr(12'h341, 32'hFFFF_FFFF);
    push_exp("mepc_rd_align", 32'hFFFF_FFFC); read_csr(12'h341, rd); check(rd);
    write_csr(12'h123, 32'hDEAD_BEEF);
    push_exp("unmapped_rd", 32'h0); read_csr(12'h123, rd); check(rd);

    // MIE=1, intr rising -> intr_req exactly 4 edges later.
    write_csr(12'h300, 32'h0000_0008);
    push_exp("mie_set", 32'h1); check({31'b0, mie});
    push_exp("mstatus_rd_8", 32'h8); read_csr(12'h300, rd); check(rd);
    intr = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      push_exp($sformatf("latency_edge%0d", i), 32'h0); check({31'b0, intr_req});
    end
    step();
    push_exp("latency_edge4", 32'h1); check({31'b0, intr_req});
    intr = 1'b0;

    // Trap entry.
    int_taken = 1'b1; pc = 32'h40;
    step();
    int_taken = 1'b0;
    push_exp("trap_mepc", 32'h40);       check(mepc);
    push_exp("trap_mie", 32'h0);         check({31'b0, mie});
    push_exp("trap_mstatus", 32'h80);    read_csr(12'h300, rd); check(rd);
    push_exp("trap_mcause", MCAUSE_EXP); read_csr(12'h342, rd); check(rd);
    step();
    push_exp("trap_req_drop", 32'h0); check({31'b0, intr_req});

    // MIE=0: edge stays pending, then surfaces once MIE is set.
    intr = 1'b1;
    repeat (3) step();
    intr = 1'b0;
    repeat (4) step();
    push_exp("masked_req", 32'h0); check({31'b0, intr_req});
    write_csr(12'h300, 32'h0000_0008);
    push_exp("unmask_same_edge", 32'h0); check({31'b0, intr_req});
    step();
    push_exp("unmask_next_edge", 32'h1); check({31'b0, intr_req});

    // int_taken beats a same-cycle mepc write.
    int_taken = 1'b1; pc = 32'h80;
    csr_we = 1'b1; csr_addr = 12'h341; csr_wd = 32'h1234;
    step();
    int_taken = 1'b0; csr_we = 1'b0;
    push_exp("prio_mepc", 32'h80);    check(mepc);
    push_exp("prio_mstatus", 32'h80); read_csr(12'h300, rd); check(rd);
    step();
    push_exp("prio_req_drop", 32'h0); check({31'b0, intr_req});

    // mret beats a same-cycle mstatus write.
    mret_exec = 1'b1; csr_we = 1'b1; csr_addr = 12'h300; csr_wd = 32'h0;
    step();
    mret_exec = 1'b0; csr_we = 1'b0;
    push_exp("mret_mie", 32'h1);      check({31'b0, mie});
    push_exp("mret_mstatus", 32'h88); read_csr(12'h300, rd); check(rd);

    // int_taken with intr_req low still traps; mtvec write in that cycle completes.
    int_taken = 1'b1; pc = 32'hC0;
    csr_we = 1'b1; csr_addr = 12'h305; csr_wd = 32'h0000_0203;
    step();
    int_taken = 1'b0; csr_we = 1'b0;
    push_exp("forced_mepc", 32'hC0);       check(mepc);
    push_exp("forced_mtvec", 32'h200);     check(mtvec);
    push_exp("forced_mstatus", 32'h80);    read_csr(12'h300, rd); check(rd);
    push_exp("forced_mcause", MCAUSE_EXP); read_csr(12'h342, rd); check(rd);
    mret_exec = 1'b1;
    step();
    mret_exec = 1'b0;
    push_exp("mret2_mstatus", 32'h88); read_csr(12'h300, rd); check(rd);
    push_exp("mret2_req", 32'h0);      check({31'b0, intr_req});

    // Reset during int_taken with intr held high.
    intr = 1'b1;
    repeat (5) step();
    int_taken = 1'b1; pc = 32'h44;
    rst_n = 1'b0;
    step();
    int_taken = 1'b0;
    push_exp("rst_mie", 32'h0);      check({31'b0, mie});
    push_exp("rst_mepc", 32'h0);     check(mepc);
    push_exp("rst_mtvec", 32'h0);    check(mtvec);
    push_exp("rst_req", 32'h0);      check({31'b0, intr_req});
    push_exp("rst_mstatus", 32'h0);  read_csr(12'h300, rd); check(rd);
    push_exp("rst_mcause", 32'h0);   read_csr(12'h342, rd); check(rd);
    @(negedge clk); rst_n = 1'b1;

    // Released mid-level: no pending until a genuine new edge.
    repeat (6) step();
    write_csr(12'h300, 32'h0000_0008);
    repeat (3) step();
    push_exp("midlevel_no_req", 32'h0); check({31'b0, intr_req});
    intr = 1'b0;
    repeat (3) step();
    intr = 1'b1;
    repeat (4) step();
    push_exp("midlevel_new_edge", 32'h1); check({31'b0, intr_req});

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
